// File: rtl/adc_monitor_pkg.sv
// Shared ADC definitions: converter rate, FSM states
// and fault codes used by the sampling monitor.
package adc_monitor_pkg;

  localparam int ADC_W = 12;
  localparam int ADC_CLK_HZ = 48_000_000;
  localparam int ADC_RATE_HZ = 10_000;
  localparam int DEF_SAMPLE_PERIOD = ADC_CLK_HZ / ADC_RATE_HZ;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_REQ    = 2'd2,
    ST_UPDATE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE    = 2'b00,
    FC_OVER    = 2'b01,
    FC_UNDER   = 2'b10,
    FC_TIMEOUT = 2'b11
  } fault_code_e;

endpackage

// File: rtl/adc_done_sync.sv
// Two-flop synchronizer for the converter done line
// plus rising-edge detect on the synchronized level.
module adc_done_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/up_counter.sv
// Free-running up counter with synchronous clear,
// shared by the sample-period and timeout timers.
module up_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/adc_monitor.sv
// Periodic ADC sampler with windowed mean and
// sticky over/under/timeout fault reporting.
module adc_monitor
  import adc_monitor_pkg::*;
#(
  parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD,
  parameter int AVG_LOG2      = 3,
  parameter int TIMEOUT       = 2048,
  parameter int FAULT_COUNT   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [ADC_W-1:0] adc_value,
  input  logic             adc_done,
  input  logic [ADC_W-1:0] thr_high,
  input  logic [ADC_W-1:0] thr_low,
  input  logic             clear_fault,
  output logic             adc_read,
  output logic [ADC_W-1:0] avg,
  output logic             avg_valid,
  output logic             fault,
  output logic [1:0]       fault_code
);

  localparam int N  = 1 << AVG_LOG2;
  localparam int SW = ADC_W + AVG_LOG2;
  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam int TW = $clog2(TIMEOUT);
  localparam int CW = $clog2(FAULT_COUNT + 1);
  localparam int FW = AVG_LOG2 + 1;

  localparam logic [PW-1:0] PER_LAST = PW'(SAMPLE_PERIOD - 2);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] FC_MAX   = CW'(FAULT_COUNT);

  state_e state_q, state_d;

  logic [PW-1:0] per_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          done_rise;

  logic [ADC_W-1:0]        sample_q, sample_d;
  logic [N-1:0][ADC_W-1:0] buf_q, buf_d;
  logic [AVG_LOG2-1:0]     wptr_q, wptr_d;
  logic [SW-1:0]           sum_q, sum_d;
  logic [FW-1:0]           fill_q, fill_d;
  logic [ADC_W-1:0]        avg_q, avg_d;
  logic                    avg_valid_q, avg_valid_d;
  logic [CW-1:0]           over_q, over_d;
  logic [CW-1:0]           under_q, under_d;
  logic                    fault_q, fault_d;
  fault_code_e             code_q, code_d;
  logic                    read_q, read_d;

  logic             new_fault;
  fault_code_e      new_code;
  logic [ADC_W-1:0] avg_n;

  adc_done_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (adc_done),
    .rise     (done_rise)
  );

  up_counter #(.W(PW)) u_per (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q != ST_WAIT),
    .en    (state_q == ST_WAIT),
    .cnt   (per_cnt)
  );

  up_counter #(.W(TW)) u_tmo (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q != ST_REQ),
    .en    (state_q == ST_REQ),
    .cnt   (tmo_cnt)
  );

  always_comb begin
    state_d     = state_q;
    sample_d    = sample_q;
    buf_d       = buf_q;
    wptr_d      = wptr_q;
    sum_d       = sum_q;
    fill_d      = fill_q;
    avg_d       = avg_q;
    avg_valid_d = 1'b0;
    over_d      = over_q;
    under_d     = under_q;
    fault_d     = fault_q;
    code_d      = code_q;
    new_fault   = 1'b0;
    new_code    = FC_NONE;
    avg_n       = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (per_cnt == PER_LAST) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (done_rise) begin
          state_d  = ST_UPDATE;
          sample_d = adc_value;
        end else if (tmo_cnt == TMO_LAST) begin
          state_d   = ST_WAIT;
          new_fault = 1'b1;
          new_code  = FC_TIMEOUT;
        end
      end
      ST_UPDATE: begin
        state_d       = ST_WAIT;
        buf_d[wptr_q] = sample_q;
        wptr_d        = wptr_q + AVG_LOG2'(1);
        sum_d = sum_q - SW'(buf_q[wptr_q])
              + SW'(sample_q);
        if (!fill_q[AVG_LOG2]) begin
          fill_d = fill_q + FW'(1);
        end
        // Averages only count once the window holds N real samples
        if (fill_d[AVG_LOG2]) begin
          avg_n       = sum_d[SW-1:AVG_LOG2];
          avg_d       = avg_n;
          avg_valid_d = 1'b1;
          if (avg_n > thr_high) begin
            over_d  = (over_q == FC_MAX) ? over_q
                    : over_q + CW'(1);
            under_d = '0;
          end else if (avg_n < thr_low) begin
            under_d = (under_q == FC_MAX) ? under_q
                    : under_q + CW'(1);
            over_d  = '0;
          end else begin
            over_d  = '0;
            under_d = '0;
          end
          if (over_d == FC_MAX) begin
            new_fault = 1'b1;
            new_code  = FC_OVER;
          end else if (under_d == FC_MAX) begin
            new_fault = 1'b1;
            new_code  = FC_UNDER;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!enable) begin
      state_d     = ST_IDLE;
      buf_d       = '0;
      wptr_d      = '0;
      sum_d       = '0;
      fill_d      = '0;
      avg_d       = avg_q;
      avg_valid_d = 1'b0;
      over_d      = '0;
      under_d     = '0;
      new_fault   = 1'b0;
    end

    // A fresh fault beats a simultaneous clear
    if (new_fault && (!fault_q || clear_fault)) begin
      fault_d = 1'b1;
      code_d  = new_code;
    end else if (clear_fault) begin
      fault_d = 1'b0;
      code_d  = FC_NONE;
    end

    read_d = (state_d == ST_REQ);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sample_q    <= '0;
      buf_q       <= '0;
      wptr_q      <= '0;
      sum_q       <= '0;
      fill_q      <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      over_q      <= '0;
      under_q     <= '0;
      fault_q     <= 1'b0;
      code_q      <= FC_NONE;
      read_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sample_q    <= sample_d;
      buf_q       <= buf_d;
      wptr_q      <= wptr_d;
      sum_q       <= sum_d;
      fill_q      <= fill_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
      over_q      <= over_d;
      under_q     <= under_d;
      fault_q     <= fault_d;
      code_q      <= code_d;
      read_q      <= read_d;
    end
  end

  assign adc_read   = read_q;
  assign avg        = avg_q;
  assign avg_valid  = avg_valid_q;
  assign fault      = fault_q;
  assign fault_code = code_q;

endmodule

// File: tb/tb_adc_monitor.sv
// Scoreboard bench for adc_monitor with a simple
// converter model answering read requests.
module tb_adc_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [11:0] adc_value;
  logic        adc_done;
  logic [11:0] thr_high;
  logic [11:0] thr_low;
  logic        clear_fault;
  logic        adc_read;
  logic [11:0] avg;
  logic        avg_valid;
  logic        fault;
  logic [1:0]  fault_code;

  typedef struct packed {
    logic [11:0] a;
    logic        f;
    logic [1:0]  c;
  } exp_t;

  exp_t        exp_q[$];
  logic [11:0] samp_q[$];
  int          errors = 0;
  int          checks = 0;

  adc_monitor #(
    .SAMPLE_PERIOD (16),
    .AVG_LOG2      (2),
    .TIMEOUT       (64),
    .FAULT_COUNT   (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .adc_value   (adc_value),
    .adc_done    (adc_done),
    .thr_high    (thr_high),
    .thr_low     (thr_low),
    .clear_fault (clear_fault),
    .adc_read    (adc_read),
    .avg         (avg),
    .avg_valid   (avg_valid),
    .fault       (fault),
    .fault_code  (fault_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, req);
    end
  endtask

  task automatic expect_avg(input logic [11:0] a,
                            input logic f,
                            input logic [1:0] c);
    exp_t e;
    e.a = a;
    e.f = f;
    e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic push_n(input logic [11:0] v, input int n);
    for (int i = 0; i < n; i++) samp_q.push_back(v);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_read(input logic lvl, input string name);
    int n;
    n = 0;
    while (adc_read !== lvl && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(name, adc_read, lvl);
  endtask

  task automatic stop_run();
    @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_fault = 1'b1;
    @(negedge clk);
    clear_fault = 1'b0;
  endtask

  // Converter: answers a request a few cycles later, off the clk edge
  initial begin
    adc_done  = 1'b0;
    adc_value = '0;
    forever begin
      @(negedge clk);
      if (adc_read && samp_q.size() > 0) begin
        repeat (2) @(negedge clk);
        #2;
        adc_value = samp_q.pop_front();
        adc_done  = 1'b1;
        for (int i = 0; i < 300 && adc_read; i++)
          @(negedge clk);
        #3;
        adc_done = 1'b0;
      end
    end
  end

  // Monitor: every avg_valid must match the next expected entry
  always @(negedge clk) begin
    if (avg_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_avg_valid avg=%0h", avg);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("avg", avg, e.a);
        chk("avg_fault", fault, e.f);
        chk("avg_code", fault_code, e.c);
      end
    end
  end

  initial begin
    int n;
    reset       = 1'b1;
    enable      = 1'b0;
    thr_high    = 12'hFFF;
    thr_low     = 12'h000;
    clear_fault = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_read", adc_read, 0);
    chk("rst_avg", avg, 0);
    chk("rst_valid", avg_valid, 0);
    chk("rst_fault", fault, 0);
    chk("rst_code", fault_code, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Steady 0x400
    thr_low  = 12'h100;
    thr_high = 12'hF00;
    push_n(12'h400, 5);
    expect_avg(12'h400, 0, 2'b00);
    expect_avg(12'h400, 0, 2'b00);
    enable = 1'b1;
    drain("steady_drain");
    chk("steady_fault", fault, 0);
    stop_run();

    // Window arithmetic incl. full-scale
    thr_low  = 12'h000;
    thr_high = 12'hFFF;
    samp_q.push_back(12'h000);
    samp_q.push_back(12'h004);
    samp_q.push_back(12'h008);
    samp_q.push_back(12'h00C);
    samp_q.push_back(12'h010);
    push_n(12'hFFF, 4);
    expect_avg(12'h006, 0, 2'b00);
    expect_avg(12'h00A, 0, 2'b00);
    expect_avg(12'h408, 0, 2'b00);
    expect_avg(12'h806, 0, 2'b00);
    expect_avg(12'hC03, 0, 2'b00);
    expect_avg(12'hFFF, 0, 2'b00);
    enable = 1'b1;
    drain("window_drain");
    stop_run();

    // Over-limit on second consecutive average
    thr_high = 12'hD00;
    push_n(12'hE00, 5);
    expect_avg(12'hE00, 0, 2'b00);
    expect_avg(12'hE00, 1, 2'b01);
    enable = 1'b1;
    drain("over_drain");
    pulse_clear();
    chk("clear_fault", fault, 0);
    chk("clear_code", fault_code, 0);
    stop_run();

    // Timeout: no done from the converter
    thr_high = 12'hFFF;
    enable   = 1'b1;
    wait_read(1'b1, "tmo_req_seen");
    n = 0;
    while (adc_read && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_read_len", n, 64);
    chk("tmo_fault", fault, 1);
    chk("tmo_code", fault_code, 2'b11);
    push_n(12'h400, 4);
    expect_avg(12'h400, 1, 2'b11);
    drain("tmo_resume_drain");
    stop_run();
    pulse_clear();
    chk("tmo_cleared", fault, 0);

    // Under-limit, then clear coinciding with another hit
    thr_low = 12'h800;
    push_n(12'h100, 6);
    expect_avg(12'h100, 0, 2'b00);
    expect_avg(12'h100, 1, 2'b10);
    expect_avg(12'h100, 1, 2'b10);
    enable = 1'b1;
    n = 0;
    while (exp_q.size() > 1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    wait_read(1'b1, "same_req_seen");
    wait_read(1'b0, "same_update_seen");
    clear_fault = 1'b1;
    @(negedge clk);
    clear_fault = 1'b0;
    drain("same_drain");
    chk("same_fault", fault, 1);
    chk("same_code", fault_code, 2'b10);

    // Enable dropped mid-request with a full window
    thr_low = 12'h000;
    wait_read(1'b1, "dis_req_seen");
    repeat (3) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("dis_read_drop", adc_read, 0);
    repeat (2) @(negedge clk);
    push_n(12'h200, 4);
    expect_avg(12'h200, 1, 2'b10);
    enable = 1'b1;
    drain("refill_drain");

    // Reset pulsed mid-request
    wait_read(1'b1, "rst_req_seen");
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_read", adc_read, 0);
    chk("mid_rst_avg", avg, 0);
    chk("mid_rst_valid", avg_valid, 0);
    chk("mid_rst_fault", fault, 0);
    chk("mid_rst_code", fault_code, 0);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (!adc_read && n < 100) begin
      @(posedge clk);
      n++;
      #1;
    end
    chk("first_req_delay", n, 16);
    enable = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
